// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding, default widths and response type for the request master.
package bus_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_t;
    localparam int BUS_ADDR_W = 4;
    localparam int BUS_DATA_W = 4;
    typedef struct packed {
        logic [BUS_DATA_W-1:0] rdata;
        logic                  err;
    } rsp_t;
endpackage

// File: rtl/bus_if.sv
// bus_if: command, slave-bus and response channels of the request master.
interface bus_if
    import bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              valid;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;
    modport master (
        input  cmd_valid, cmd_addr, cmd_wdata, cmd_write, rdata, ready, rsp_ready,
        output cmd_ready, addr, wdata, valid, rsp_valid, rsp_rdata, rsp_err, busy
    );
    modport slave (
        output cmd_valid, cmd_addr, cmd_wdata, cmd_write, rdata, ready, rsp_ready,
        input  cmd_ready, addr, wdata, valid, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/bus_timeout_cnt.sv
// bus_timeout_cnt: counts slave-wait cycles and flags the last one before the request is abandoned.
module bus_timeout_cnt #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    assign expire = cnt_q == CNT_W'(TIMEOUT - 1);
    always_ff @(posedge clock) cnt_q <= !reset_n ? '0 : cnt_d;
endmodule

// File: rtl/bus_req_master.sv
// bus_req_master: issues one slave-bus transaction per accepted command and returns
// read data or a timeout error on a backpressured response channel.
module bus_req_master
    import bus_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input logic   clock,
    input logic   reset_n,
    bus_if.master bus
);
    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rsp_rdata_q;
    logic              write_q, valid_q, rsp_valid_q, rsp_err_q, busy_q, expire;

    bus_timeout_cnt #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_cnt (
        .clock  (clock),
        .reset_n(reset_n),
        .clr    (state_q == IDLE),
        .en     (state_q == REQ),
        .expire (expire)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            valid_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.cmd_valid) begin
                    addr_q  <= bus.cmd_addr;
                    wdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
                    write_q <= bus.cmd_write;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= REQ;
                end
                // ready takes priority over an expiring counter in the same cycle
                REQ: if (bus.ready || expire) begin
                    rsp_rdata_q <= (bus.ready && !write_q) ? bus.rdata : '0;
                    rsp_err_q   <= !bus.ready;
                    valid_q     <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RSP;
                end
                RSP: if (bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = state_q == IDLE;
    assign bus.addr      = addr_q;
    assign bus.wdata     = wdata_q;
    assign bus.valid     = valid_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/bus_req_master.md
Name: bus_req_master

Overview:
Request-issuing stage that sits directly upstream of the 4-bit addr/wdata/valid -> rdata/ready slave bus.
- Accepts commands from a producer over a valid/ready channel.
- Drives one bus transaction at a time and waits for the slave's ready.
- Returns read data, or a timeout error, on a backpressured response channel.
- Lets the top level hang the slave off a sequenced master instead of a constant valid.

Parameters:
ADDR_W, 4, width of addr and cmd_addr
DATA_W, 4, width of wdata, rdata, cmd_wdata, rsp_rdata
TIMEOUT, 15, slave-wait cycles before the request is abandoned; must be >= 1
CNT_W, 4, timeout counter width; must hold TIMEOUT

Ports:
clock  input  1  single clock; all flops on rising edge
reset_n  input  1  synchronous, active-low reset
cmd_valid  input  1  producer has a command
cmd_ready  output  1  command accepted this cycle when high with cmd_valid
cmd_addr  input  ADDR_W  command address
cmd_wdata  input  DATA_W  command write data
cmd_write  input  1  1 = write, 0 = read
addr  output  ADDR_W  bus address to slave
wdata  output  DATA_W  bus write data to slave
valid  output  1  bus request strobe
rdata  input  DATA_W  slave read data, sampled when ready is high
ready  input  1  slave completion
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes response
rsp_rdata  output  DATA_W  captured rdata; 0 for writes and timeouts
rsp_err  output  1  1 = timeout
busy  output  1  state != IDLE

Behaviour:
- Reset (reset_n low at a clock edge) values:
  - state = IDLE; addr, wdata, rsp_rdata = 0; valid, rsp_valid, rsp_err = 0; counter = 0.
  - Reset wins over every other event, including mid-transaction: an outstanding request is dropped and no response is produced.
- FSM has three states: IDLE, REQ, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: register cmd_addr onto addr, and cmd_wdata onto wdata (wdata = 0 for reads); latch cmd_write; set valid = 1; clear the counter; go to REQ.
  - Latency: valid is high in the first cycle after acceptance.
- REQ:
  - cmd_ready = 0; valid held high; addr and wdata stable.
  - If ready = 1:
    - rsp_rdata = (write ? 0 : rdata); rsp_err = 0; valid = 0; rsp_valid = 1; go to RSP.
    - A slave that holds ready high permanently completes in one cycle, so the round trip is accept -> REQ -> RSP = 2 cycles.
  - Else if counter == TIMEOUT-1: rsp_err = 1; rsp_rdata = 0; valid = 0; rsp_valid = 1; go to RSP.
  - Else counter increments; it never wraps because timeout fires first.
  - ready and timeout in the same cycle: ready wins (no error).
- RSP:
  - rsp_valid held high; rsp_rdata and rsp_err stable until rsp_ready.
  - On rsp_ready: rsp_valid = 0 and go to IDLE.
  - cmd_ready stays 0 in RSP. There is no command/response overlap, so at most one transaction is in flight.
  - The next command is accepted no earlier than the cycle after the response handshake.
- ready is ignored in IDLE and RSP.
- All outputs are registered except cmd_ready, which is decoded combinationally from state.
- Widths: the counter compare is at CNT_W; rdata is captured with no extension.

Decomposition:
- Shared package bus_pkg holds:
  - state enum: IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2;
  - default widths ADDR_W / DATA_W = 4;
  - a response struct {rdata, err}.
- One natural sub-module, bus_timeout_cnt: clear / enable / expire, parameterised by TIMEOUT and CNT_W. Everything else stays in bus_req_master.

Test Plan:
- Read, slave ready tied to 1, rdata = 4'h5: send cmd_addr = 4'ha, write = 0 -> valid rises the cycle after acceptance and is high 1 cycle with addr = 4'ha; rsp_valid = 1 with rsp_rdata = 4'h5, rsp_err = 0, 2 cycles after acceptance.
- Write with addr = 4'ha, wdata = 4'h4, ready asserted after 3 wait cycles -> valid high 4 cycles with addr/wdata stable; rsp_rdata = 0, rsp_err = 0.
- Timeout with ready held 0 and TIMEOUT = 15 -> valid high exactly 15 cycles, then rsp_err = 1, rsp_rdata = 0; a following command completes normally.
- Backpressure: hold rsp_ready = 0 for 5 cycles with cmd_valid high -> rsp_valid and rsp_rdata stable, cmd_ready = 0 throughout; the second command is accepted only after the handshake.
- Reset mid-REQ: assert reset_n = 0 on the 2nd wait cycle -> next cycle valid = 0, rsp_valid = 0, busy = 0, cmd_ready = 1; no stale response afterwards.
- ready on the TIMEOUT-1 cycle -> normal response with rsp_err = 0 and rdata captured.
